// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, control encodings and the ID/EX control bundle; DECODE_MEXT_EN adds the MDU fields.
package decode_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR,
    ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_JALR} wb_sel_e;
  typedef enum logic [2:0] {LD_NONE, LD_LB, LD_LH, LD_LBU, LD_LHU, LD_LW} load_sel_e;
  typedef enum logic [1:0] {ST_NONE, ST_SB, ST_SH, ST_SW} store_sel_e;
  typedef struct packed {
    logic       rd_wren;
    logic       op_a_sel;
    logic       op_b_sel;
    logic       mem_wren;
    logic       br_unsigned;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    alu_op_e    alu_op;
    wb_sel_e    wb_sel;
    load_sel_e  load_sel;
    store_sel_e store_sel;
    logic [2:0] br_type;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       insn_vld;
`ifdef DECODE_MEXT_EN
    logic       mdu_vld;
    logic [2:0] mdu_op;
`endif
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  // sub only applies to R-type funct3 000; sra to funct3 101 of both R and I forms
  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic sub, input logic sra);
    case (f3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return sra ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational RV32I instruction to ctrl_t decode plus source-register usage flags.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        use_rs1,
  output logic        use_rs2
);
  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       legal;
  ctrl_t      c;
  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  always_comb begin
    c = CTRL_NOP;
    c.rs1 = instr[19:15];
    c.rs2 = instr[24:20];
    c.rd = instr[11:7];
    legal = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        c.rd_wren = 1'b1;
        c.alu_op = alu_dec(f3, f7[5], f7[5]);
        c.br_unsigned = f3 == 3'b011;
`ifdef DECODE_MEXT_EN
        if (f7 == 7'b0000001) begin
          c.alu_op = ALU_ADD;
          c.br_unsigned = 1'b0;
          c.mdu_vld = 1'b1;
          c.mdu_op = f3;
        end else
          legal = f7 == 7'b0000000 || f7 == 7'b0100000;
`else
        legal = f7 == 7'b0000000 || f7 == 7'b0100000;
`endif
      end
      OP_I: begin
        use_rs1 = 1'b1;
        c.rd_wren = 1'b1;
        c.op_b_sel = 1'b1;
        c.alu_op = alu_dec(f3, 1'b0, f7[5]);
        c.br_unsigned = f3 == 3'b011;
        legal = f3 == 3'b001 ? f7 == 7'b0000000 :
                f3 != 3'b101 || f7 == 7'b0000000 || f7 == 7'b0100000;
      end
      OP_LOAD: begin
        use_rs1 = 1'b1;
        c.rd_wren = 1'b1;
        c.op_b_sel = 1'b1;
        c.wb_sel = WB_MEM;
        c.load_sel = f3 == 3'b000 ? LD_LB  : f3 == 3'b001 ? LD_LH :
                     f3 == 3'b010 ? LD_LW  : f3 == 3'b100 ? LD_LBU :
                     f3 == 3'b101 ? LD_LHU : LD_NONE;
        legal = c.load_sel != LD_NONE;
      end
      OP_S: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        c.mem_wren = 1'b1;
        c.op_b_sel = 1'b1;
        c.store_sel = f3 == 3'b000 ? ST_SB : f3 == 3'b001 ? ST_SH :
                      f3 == 3'b010 ? ST_SW : ST_NONE;
        legal = c.store_sel != ST_NONE;
      end
      OP_B: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        c.is_branch = 1'b1;
        c.op_a_sel = 1'b1;
        c.op_b_sel = 1'b1;
        c.br_type = f3;
        c.br_unsigned = f3[2:1] == 2'b11;
        legal = f3[2:1] != 2'b01;
      end
      OP_LUI: begin
        c.rd_wren = 1'b1;
        c.op_b_sel = 1'b1;
        c.alu_op = ALU_LUI;
      end
      OP_AUIPC: begin
        c.rd_wren = 1'b1;
        c.op_a_sel = 1'b1;
        c.op_b_sel = 1'b1;
      end
      OP_JAL: begin
        c.rd_wren = 1'b1;
        c.op_a_sel = 1'b1;
        c.op_b_sel = 1'b1;
        c.is_jal = 1'b1;
        c.wb_sel = WB_PC4;
      end
      OP_JALR: begin
        use_rs1 = 1'b1;
        c.rd_wren = 1'b1;
        c.op_b_sel = 1'b1;
        c.is_jalr = 1'b1;
        c.wb_sel = WB_JALR;
      end
      default: legal = 1'b0;
    endcase
    c.insn_vld = legal;
    ctrl = legal ? c : CTRL_NOP;
  end
endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: RV32I decode/control stage with ID/EX control register, load-use stall and illegal counter.
module decode_ctrl_stage
  import decode_pkg::*;
#(
  parameter int ILEN    = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ILEN-1:0]    i_instr,
  input  logic               i_instr_vld,
  output logic               o_id_ready,
  input  logic               i_ex_hold,
  input  logic               i_flush,
  output logic               o_ex_vld,
  output logic               o_ex_rd_wren,
  output logic               o_ex_op_a_sel,
  output logic               o_ex_op_b_sel,
  output logic               o_ex_mem_wren,
  output logic               o_ex_br_unsigned,
  output logic               o_ex_is_branch,
  output logic               o_ex_is_jal,
  output logic               o_ex_is_jalr,
  output logic [ALUOP_W-1:0] o_ex_alu_op,
  output logic [1:0]         o_ex_wb_sel,
  output logic [2:0]         o_ex_load_sel,
  output logic [1:0]         o_ex_store_sel,
  output logic [2:0]         o_ex_br_type,
  output logic [REG_AW-1:0]  o_ex_rs1,
  output logic [REG_AW-1:0]  o_ex_rs2,
  output logic [REG_AW-1:0]  o_ex_rd,
  output logic               o_ex_insn_vld,
`ifdef DECODE_MEXT_EN
  output logic               o_ex_mdu_vld,
  output logic [2:0]         o_ex_mdu_op,
`endif
  output logic [CNT_W-1:0]   o_illegal_cnt
);
  ctrl_t            dec;
  ctrl_t            ex;
  logic             ex_vld;
  logic             use_rs1;
  logic             use_rs2;
  logic             hazard;
  logic             load;
  logic [CNT_W-1:0] cnt;
  decode_comb u_dec (
    .instr   (i_instr[31:0]),
    .ctrl    (dec),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );
  // illegal instructions decode to all-zero controls, so only a real load can raise this
  assign hazard = i_instr_vld && ex_vld && ex.wb_sel == WB_MEM && ex.rd != 5'd0 &&
                  ((use_rs1 && ex.rd == dec.rs1) || (use_rs2 && ex.rd == dec.rs2));
  assign o_id_ready = i_flush || (!i_ex_hold && !hazard);
  assign load = i_instr_vld && !hazard;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex <= CTRL_NOP;
      ex_vld <= 1'b0;
      cnt <= '0;
    end else if (i_flush) begin
      ex <= CTRL_NOP;
      ex_vld <= 1'b0;
    end else if (!i_ex_hold) begin
      ex <= load ? dec : CTRL_NOP;
      ex_vld <= load;
      if (load && !dec.insn_vld && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
  assign o_ex_vld         = ex_vld;
  assign o_ex_rd_wren     = ex.rd_wren;
  assign o_ex_op_a_sel    = ex.op_a_sel;
  assign o_ex_op_b_sel    = ex.op_b_sel;
  assign o_ex_mem_wren    = ex.mem_wren;
  assign o_ex_br_unsigned = ex.br_unsigned;
  assign o_ex_is_branch   = ex.is_branch;
  assign o_ex_is_jal      = ex.is_jal;
  assign o_ex_is_jalr     = ex.is_jalr;
  assign o_ex_alu_op      = ALUOP_W'(ex.alu_op);
  assign o_ex_wb_sel      = ex.wb_sel;
  assign o_ex_load_sel    = ex.load_sel;
  assign o_ex_store_sel   = ex.store_sel;
  assign o_ex_br_type     = ex.br_type;
  assign o_ex_rs1         = REG_AW'(ex.rs1);
  assign o_ex_rs2         = REG_AW'(ex.rs2);
  assign o_ex_rd          = REG_AW'(ex.rd);
  assign o_ex_insn_vld    = ex.insn_vld;
`ifdef DECODE_MEXT_EN
  assign o_ex_mdu_vld     = ex.mdu_vld;
  assign o_ex_mdu_op      = ex.mdu_op;
`endif
  assign o_illegal_cnt    = cnt;
endmodule
